mod_reg16_1to16: RTL and testbench
==================================

Name: mod_reg16_1to16

Overview:
- Byte-serial to block-parallel collector: accepts one 8-bit byte per handshake and assembles an N-byte (default 16 = one AES state) block.
- Presents the block in parallel with a full flag until the consumer takes it.
- Sits at the opposite end of the 16-to-1 byte FIFO: feeds 128-bit stages (addRK/sub-bytes) from a byte-wide source.

Parameters:
N  16  number of bytes per block
W  8  byte width in bits

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
wr_en  input  1  byte-valid strobe from producer
i  input  W  byte to store
in_ready  output  1  1 = block can accept a byte this cycle
rd_en  input  1  consumer takes the assembled block
clr  input  1  synchronous abort: discard partial block
o  output  [N-1:0][W-1:0]  assembled block; o[0] = first byte received
reg_full  output  1  1 = all N bytes valid on o
byte_cnt  output  $clog2(N)+1  bytes stored in current block (0..N)
ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. All other state changes on rising clk.
- Reset values:
  - o = all zero, byte_cnt = 0, reg_full = 0, in_ready = 1, ovf = 0.
  - State = FILL.
- States:
  - FILL (collecting).
  - FULL (block held).
- FILL:
  - in_ready = 1.
  - On wr_en: o[byte_cnt] <= i; byte_cnt <= byte_cnt + 1.
  - The write that makes byte_cnt = N moves to FULL. reg_full rises the cycle after the Nth accepted edge.
  - rd_en in FILL is ignored.
- FULL:
  - in_ready = 0, reg_full = 1, o stable.
  - wr_en is ignored: no data change, no counter change.
  - On rd_en: byte_cnt <= 0, reg_full <= 0, go to FILL. in_ready = 1 the next cycle.
  - o retains the old block until overwritten byte by byte. Stale bytes at index >= byte_cnt are don't-care to consumers.
- Simultaneous rd_en and wr_en in FULL: rd_en wins; the byte is dropped. The producer must watch in_ready.
- clr: highest synchronous priority in any state.
  - byte_cnt <= 0, reg_full <= 0, state FILL.
  - o is not cleared.
  - A wr_en on the same edge is dropped.
- Handshake:
  - A byte is accepted iff wr_en & in_ready & !clr at the rising edge.
  - in_ready is a registered function of state; no combinational path from wr_en or i to any output.
- byte_cnt never exceeds N and never wraps. Index arithmetic uses $clog2(N) bits; only values 0..N-1 address o.
- Reset asserted mid-block: immediate return to reset values; the partial block is lost.
- Back-to-back operation:
  - N consecutive wr_en cycles fill a block in N cycles.
  - rd_en in the first FULL cycle allows the next byte on the following cycle.
  - Throughput: N bytes per N+1 cycles.

Optional Feature:
- Macro: MOD_REG16_1TO16_OVF_EN.
- Defined:
  - ovf sets to 1 on any edge where wr_en = 1 and in_ready = 0 (FULL, or FULL with rd_en), excluding edges where clr = 1.
  - ovf is sticky; cleared only by reset or clr.
- Undefined: ovf tied to constant 0, no overflow logic synthesized. Port list is unchanged.

Test Plan:
1. Reset, then write bytes 8'h00..8'h0F on 16 consecutive cycles -> reg_full = 1 one cycle after the 16th edge; o[k] = k; byte_cnt = 16; in_ready = 0.
2. From FULL, pulse rd_en, then write 8'h00,8'h02,...,8'h1E with one idle cycle between bytes -> reg_full = 0 during fill; final o[k] = 2k; reg_full = 1.
3. In FULL, assert wr_en with i = 8'hAA for 3 cycles -> o unchanged, byte_cnt = 16. With MOD_REG16_1TO16_OVF_EN: ovf = 1 and stays 1 after rd_en. Without the macro: ovf = 0.
4. Write 5 bytes (8'h10..8'h14), assert clr with wr_en = 1, i = 8'hFF -> byte_cnt = 0, 8'hFF not stored. The next 16 writes of 8'h20..8'h2F give o[k] = 8'h20 + k.
5. Assert reset asynchronously (mid-cycle) after 7 bytes -> outputs return to reset values immediately, without waiting for a clk edge; byte_cnt = 0, in_ready = 1.
6. In FULL, assert rd_en and wr_en (i = 8'h55) on the same edge -> state FILL, byte_cnt = 0, 8'h55 not stored. A write of 8'h77 on the next cycle lands in o[0].

Source files
------------

// File: rtl/mod_reg16_1to16.sv
// Byte-serial to block-parallel collector: assembles N bytes into one block.
// Optional sticky overflow flag enabled by defining MOD_REG16_1TO16_OVF_EN.
module mod_reg16_1to16 #(
  parameter int N = 16,
  parameter int W = 8,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [W-1:0]        i,
  output logic                in_ready,
  input  logic                rd_en,
  input  logic                clr,
  output logic [N-1:0][W-1:0] o,
  output logic                reg_full,
  output logic [CW-1:0]       byte_cnt,
  output logic                ovf
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [CW-1:0] LP_LAST = CW'(N - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [N-1:0][W-1:0]  r_data;
  logic                 w_accept;
  logic                 w_last;
  logic [IW-1:0]        w_idx;

  // A byte lands only while collecting and no abort is pending.
  assign w_accept = wr_en & (r_state == FILL) & ~clr;
  assign w_last   = (r_cnt == LP_LAST);
  assign w_idx    = r_cnt[IW-1:0];

  // State and byte counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: clr dominates, then fill progress or block release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = FILL;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (wr_en) begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_last) begin
              w_state_nxt = FULL;
            end
          end
        end
        FULL: begin
          if (rd_en) begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  // Block storage: old bytes persist until overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data[w_idx] <= i;
    end
  end

`ifdef MOD_REG16_1TO16_OVF_EN
  logic r_ovf;

  // Sticky flag for bytes pushed while the block is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (wr_en && (r_state == FULL)) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready = (r_state == FILL);
  assign reg_full = (r_state == FULL);
  assign byte_cnt = r_cnt;
  assign o        = r_data;

endmodule

// File: tb/tb_mod_reg16_1to16.sv
// Self-checking bench for mod_reg16_1to16 against a block-level model.
// Directed scenarios followed by randomized traffic.
module tb_mod_reg16_1to16;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int CW = $clog2(N) + 1;

  logic                clk;
  logic                rst;
  logic                wr_en;
  logic [W-1:0]        din;
  logic                in_ready;
  logic                rd_en;
  logic                clr;
  logic [N-1:0][W-1:0] o;
  logic                reg_full;
  logic [CW-1:0]       byte_cnt;
  logic                ovf;

  int checks;
  int errors;

  // model: stored bytes, count, held flag, overflow
  logic [N-1:0][W-1:0] m_o;
  int                  m_cnt;
  bit                  m_full;
  bit                  m_ovf;
  bit                  ovf_en;

  mod_reg16_1to16 #(.N(N), .W(W)) dut (
    .clk(clk),
    .reset(rst),
    .wr_en(wr_en),
    .i(din),
    .in_ready(in_ready),
    .rd_en(rd_en),
    .clr(clr),
    .o(o),
    .reg_full(reg_full),
    .byte_cnt(byte_cnt),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_o    = '0;
    m_cnt  = 0;
    m_full = 0;
    m_ovf  = 0;
  endtask

  // One rising edge of the block as described in words:
  // abort beats everything; a held block only releases or flags overflow;
  // otherwise a byte goes to the next free slot.
  task automatic model_edge(input bit we, input logic [W-1:0] d,
                            input bit rd, input bit cl);
    if (cl) begin
      m_cnt  = 0;
      m_full = 0;
      m_ovf  = 0;
    end else if (m_full) begin
      if (we && ovf_en) m_ovf = 1;
      if (rd) begin
        m_full = 0;
        m_cnt  = 0;
      end
    end else if (we) begin
      m_o[m_cnt] = d;
      m_cnt++;
      if (m_cnt == N) m_full = 1;
    end
  endtask

  task automatic drive(input bit we, input logic [W-1:0] d,
                       input bit rd, input bit cl);
    wr_en = we;
    din   = d;
    rd_en = rd;
    clr   = cl;
    model_edge(we, d, rd, cl);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_o: got %h want 0", o);
    end
    checks++;
    if (byte_cnt !== '0 || reg_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_full: got cnt=%0d full=%b want 0/0",
               byte_cnt, reg_full);
    end
    checks++;
    if (in_ready !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_ovf: got rdy=%b ovf=%b want 1/0",
               in_ready, ovf);
    end
  endtask

  task automatic test_fill_seq();
    logic [N-1:0][W-1:0] exp_blk;
    for (int k = 0; k < N; k++) begin
      drive(1, W'(k), 0, 0);
      exp_blk[k] = W'(k);
      if (k == N - 2) begin
        checks++;
        if (reg_full !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL seq_not_full_early: got full=%b rdy=%b want 0/1",
                   reg_full, in_ready);
        end
      end
    end
    checks++;
    if (reg_full !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL seq_full: got full=%b rdy=%b want 1/0",
               reg_full, in_ready);
    end
    checks++;
    if (byte_cnt !== CW'(N)) begin
      errors++;
      $display("FAIL seq_cnt: got %0d want %0d", byte_cnt, N);
    end
    checks++;
    if (o !== exp_blk) begin
      errors++;
      $display("FAIL seq_data: got %h want %h", o, exp_blk);
    end
  endtask

  task automatic test_gap_fill();
    logic [N-1:0][W-1:0] exp_blk;
    int bad;
    bad = 0;
    drive(0, '0, 1, 0);
    for (int k = 0; k < N; k++) begin
      drive(1, W'(2 * k), 0, 0);
      exp_blk[k] = W'(2 * k);
      if (k < N - 1 && reg_full !== 1'b0) bad++;
      drive(0, '0, 0, 0);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gap_full_during_fill: got %0d early-full cycles want 0",
               bad);
    end
    checks++;
    if (o !== exp_blk || reg_full !== 1'b1) begin
      errors++;
      $display("FAIL gap_data: got %h full=%b want %h full=1",
               o, reg_full, exp_blk);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0][W-1:0] held;
    held = o;
    for (int k = 0; k < 3; k++) drive(1, 8'hAA, 0, 0);
    checks++;
    if (o !== held || byte_cnt !== CW'(N)) begin
      errors++;
      $display("FAIL ovf_hold: got %h cnt=%0d want %h cnt=%0d",
               o, byte_cnt, held, N);
    end
    checks++;
    if (ovf !== ovf_en) begin
      errors++;
      $display("FAIL ovf_flag: got %b want %b", ovf, ovf_en);
    end
    drive(0, '0, 1, 0);
    checks++;
    if (ovf !== ovf_en || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b rdy=%b want %b/1",
               ovf, in_ready, ovf_en);
    end
  endtask

  task automatic test_clr();
    logic [N-1:0][W-1:0] exp_blk;
    for (int k = 0; k < 5; k++) drive(1, W'(8'h10 + k), 0, 0);
    drive(1, 8'hFF, 0, 1);
    checks++;
    if (byte_cnt !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_state: got cnt=%0d ovf=%b rdy=%b want 0/0/1",
               byte_cnt, ovf, in_ready);
    end
    checks++;
    if (o[5] === 8'hFF || o !== m_o) begin
      errors++;
      $display("FAIL clr_drop: got %h want %h", o, m_o);
    end
    for (int k = 0; k < N; k++) begin
      drive(1, W'(8'h20 + k), 0, 0);
      exp_blk[k] = W'(8'h20 + k);
    end
    checks++;
    if (o !== exp_blk || reg_full !== 1'b1) begin
      errors++;
      $display("FAIL clr_refill: got %h full=%b want %h full=1",
               o, reg_full, exp_blk);
    end
  endtask

  task automatic test_async_reset();
    drive(0, '0, 1, 0);
    for (int k = 0; k < 7; k++) drive(1, W'($urandom), 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (o !== '0 || byte_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst_data: got cnt=%0d o=%h want 0/0", byte_cnt, o);
    end
    checks++;
    if (in_ready !== 1'b1 || reg_full !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_flags: got rdy=%b full=%b ovf=%b want 1/0/0",
               in_ready, reg_full, ovf);
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_rd_wr_same();
    logic [W-1:0] old0;
    for (int k = 0; k < N; k++) drive(1, W'($urandom), 0, 0);
    old0 = o[0];
    drive(1, 8'h55, 1, 0);
    checks++;
    if (byte_cnt !== '0 || in_ready !== 1'b1 || reg_full !== 1'b0) begin
      errors++;
      $display("FAIL rdwr_state: got cnt=%0d rdy=%b full=%b want 0/1/0",
               byte_cnt, in_ready, reg_full);
    end
    checks++;
    if (o[0] !== old0) begin
      errors++;
      $display("FAIL rdwr_drop: got o0=%h want %h", o[0], old0);
    end
    drive(1, 8'h77, 0, 0);
    checks++;
    if (o[0] !== 8'h77 || byte_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL rdwr_next: got o0=%h cnt=%0d want 77/1", o[0], byte_cnt);
    end
  endtask

  task automatic test_random();
    bit we, rd, cl;
    logic [W-1:0] d;
    for (int n = 0; n < 600; n++) begin
      we = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 3);
      cl = ($urandom_range(0, 39) == 0);
      d  = W'($urandom);
      drive(we, d, rd, cl);
      checks++;
      if (byte_cnt !== CW'(m_cnt) || reg_full !== m_full ||
          in_ready !== !m_full) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got cnt=%0d full=%b rdy=%b want %0d/%b/%b",
                 n, byte_cnt, reg_full, in_ready, m_cnt, m_full, !m_full);
      end
      checks++;
      if (o !== m_o) begin
        errors++;
        $display("FAIL rand_data@%0d: got %h want %h", n, o, m_o);
      end
      checks++;
      if (ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand_ovf@%0d: got %b want %b", n, ovf, m_ovf);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef MOD_REG16_1TO16_OVF_EN
    ovf_en = 1;
`else
    ovf_en = 0;
`endif
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    din   = '0;
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    test_fill_seq();
    test_gap_fill();
    test_overflow();
    test_clr();
    test_async_reset();
    test_rd_wr_same();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
